decoder_pipe: RTL and testbench



---
 rtl/decoder_pipe.sv | 146 ++++++++++++++
 tb/tb_decoder_pipe.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/decoder_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | decoder_pipe: registered binary/thermometer decoder with a valid/ready   |
// | stream interface, two-entry skid buffer and a saturating error counter.  |
// | Optional feature macro: DECODER_THERM_EN (adds thermMode port).          |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module decoder_pipe #(
  parameter int IN_W  = 4,
  parameter int OUT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IN_W-1:0]  dataIn,
  input  logic             inValid,
  output logic             inReady,
  output logic [OUT_W-1:0] dataOut,
  output logic             outOfRange,
  output logic             outValid,
  input  logic             outReady,
  input  logic             errClr,
  output logic [7:0]       errCount
`ifdef DECODER_THERM_EN
  ,
  input  logic             thermMode
`endif
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [OUT_W-1:0] or_data_q, or_data_d;
  logic [OUT_W-1:0] sk_data_q, sk_data_d;
  logic             or_oor_q, or_oor_d;
  logic             sk_oor_q, sk_oor_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [7:0]       err_q, err_d;

  logic [OUT_W-1:0] dec_word;
  logic             dec_oor;
  logic             therm_sel;
  logic             accept;
  logic             xfer;

`ifdef DECODER_THERM_EN
  assign therm_sel = thermMode;
`else
  assign therm_sel = 1'b0;
`endif

  // An out-of-range code matches no one-hot bit and exceeds every thermometer
  // bit, so the 0 / all-ones results fall out of the per-bit compare.
  always_comb begin
    dec_oor = (32'(dataIn) >= OUT_W);
    for (int k = 0; k < OUT_W; k++) begin
      dec_word[k] = therm_sel ? (32'(dataIn) >= k) : (32'(dataIn) == k);
    end
  end

  assign accept = inValid && in_ready_q;
  assign xfer   = out_valid_q && outReady;

  always_comb begin
    state_d   = state_q;
    or_data_d = or_data_q;
    or_oor_d  = or_oor_q;
    sk_data_d = sk_data_q;
    sk_oor_d  = sk_oor_q;
    case (state_q)
      S_EMPTY: begin
        if (accept) begin
          or_data_d = dec_word;
          or_oor_d  = dec_oor;
          state_d   = S_ONE;
        end
      end
      S_ONE: begin
        if (accept && xfer) begin
          or_data_d = dec_word;
          or_oor_d  = dec_oor;
        end else if (accept) begin
          sk_data_d = dec_word;
          sk_oor_d  = dec_oor;
          state_d   = S_TWO;
        end else if (xfer) begin
          state_d   = S_EMPTY;
        end
      end
      S_TWO: begin
        if (xfer) begin
          or_data_d = sk_data_q;
          or_oor_d  = sk_oor_q;
          state_d   = S_ONE;
        end
      end
      default: state_d = S_EMPTY;
    endcase
    in_ready_d  = (state_d != S_TWO);
    out_valid_d = (state_d != S_EMPTY);
  end

  // Clear wins over a simultaneous increment.
  always_comb begin
    err_d = err_q;
    if (errClr) begin
      err_d = 8'd0;
    end else if (accept && dec_oor && (err_q != 8'hFF)) begin
      err_d = err_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_EMPTY;
      or_data_q   <= '0;
      or_oor_q    <= 1'b0;
      sk_data_q   <= '0;
      sk_oor_q    <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      err_q       <= 8'd0;
    end else begin
      state_q     <= state_d;
      or_data_q   <= or_data_d;
      or_oor_q    <= or_oor_d;
      sk_data_q   <= sk_data_d;
      sk_oor_q    <= sk_oor_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      err_q       <= err_d;
    end
  end

  assign inReady    = in_ready_q;
  assign outValid   = out_valid_q;
  assign dataOut    = or_data_q;
  assign outOfRange = or_oor_q;
  assign errCount   = err_q;

endmodule
`default_nettype wire

// File: tb/tb_decoder_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_decoder_pipe: scoreboard bench for decoder_pipe, one 16-output and    |
// | one 10-output instance driven by the same stream.                        |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_decoder_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  dataIn;
  logic        inValid, outReady, errClr, thermMode;

  logic        a_inReady, a_oor, a_outValid;
  logic [15:0] a_dout;
  logic [7:0]  a_errCount;
  logic        b_inReady, b_oor, b_outValid;
  logic [9:0]  b_dout;
  logic [7:0]  b_errCount;

  int          checks = 0;
  int          errors = 0;
  logic [16:0] qa[$];
  logic [16:0] qb[$];
  int          cnt_a = 0, cnt_b = 0;
  bit          acc_a = 0, acc_b = 0, clr_p = 0, mon_en = 0;
  logic [16:0] exp_a, exp_b;

  always #5 clk = ~clk;

  decoder_pipe #(.IN_W(4), .OUT_W(16)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .dataIn(dataIn), .inValid(inValid), .inReady(a_inReady),
    .dataOut(a_dout), .outOfRange(a_oor), .outValid(a_outValid), .outReady(outReady),
    .errClr(errClr), .errCount(a_errCount)
`ifdef DECODER_THERM_EN
    , .thermMode(thermMode)
`endif
  );

  decoder_pipe #(.IN_W(4), .OUT_W(10)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .dataIn(dataIn), .inValid(inValid), .inReady(b_inReady),
    .dataOut(b_dout), .outOfRange(b_oor), .outValid(b_outValid), .outReady(outReady),
    .errClr(errClr), .errCount(b_errCount)
`ifdef DECODER_THERM_EN
    , .thermMode(thermMode)
`endif
  );

  // Reference decode: {outOfRange, word} for an output width w.
  function automatic logic [16:0] model(input int code, input int w, input bit therm);
    logic [15:0] word;
    logic        oor;
    oor = (code >= w);
    if (oor)        word = therm ? 16'((1 << w) - 1) : 16'd0;
    else if (therm) word = 16'((1 << (code + 1)) - 1);
    else            word = 16'(1 << code);
    return {oor, word};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Retire the accept (and clear) that took place at the posedge just passed.
  task automatic commit();
    if (acc_a) begin
      qa.push_back(exp_a);
      if (exp_a[16] && cnt_a < 255) cnt_a++;
    end
    if (acc_b) begin
      qb.push_back(exp_b);
      if (exp_b[16] && cnt_b < 255) cnt_b++;
    end
    if (clr_p) begin
      cnt_a = 0;
      cnt_b = 0;
    end
  endtask

  task automatic step(input bit v, input int c, input bit rdy, input bit clr, input bit tm);
    bit tm_eff;
    @(posedge clk);
    #1;
    commit();
`ifdef DECODER_THERM_EN
    tm_eff = tm;
`else
    tm_eff = 1'b0;
`endif
    dataIn    = 4'(c);
    inValid   = v;
    outReady  = rdy;
    errClr    = clr;
    thermMode = tm;
    acc_a     = v && a_inReady;
    acc_b     = v && b_inReady;
    exp_a     = model(c, 16, tm_eff);
    exp_b     = model(c, 10, tm_eff);
    clr_p     = clr;
  endtask

  task automatic check_reset_values();
    check("rst_a_outValid", a_outValid, 0);
    check("rst_a_inReady",  a_inReady,  1);
    check("rst_a_dataOut",  a_dout,     0);
    check("rst_a_oor",      a_oor,      0);
    check("rst_a_errCount", a_errCount, 0);
    check("rst_b_outValid", b_outValid, 0);
    check("rst_b_inReady",  b_inReady,  1);
    check("rst_b_errCount", b_errCount, 0);
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #1;
    inValid = 1'b0;
    errClr  = 1'b0;
    rst_n   = 1'b0;
    #1;
    check_reset_values();
    qa.delete();
    qb.delete();
    cnt_a = 0;
    cnt_b = 0;
    acc_a = 0;
    acc_b = 0;
    clr_p = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Occupancy, counter and beat order are all judged against the queues.
  always @(negedge clk) begin
    if (rst_n && mon_en) begin
      check("a_inReady",  a_inReady,  qa.size() < 2);
      check("a_outValid", a_outValid, qa.size() > 0);
      check("a_errCount", a_errCount, cnt_a);
      if (a_outValid && qa.size() > 0) begin
        check("a_beat", {a_oor, a_dout}, qa[0]);
        if (outReady) void'(qa.pop_front());
      end
      check("b_inReady",  b_inReady,  qb.size() < 2);
      check("b_outValid", b_outValid, qb.size() > 0);
      check("b_errCount", b_errCount, cnt_b);
      if (b_outValid && qb.size() > 0) begin
        check("b_beat", {b_oor, 6'd0, b_dout}, qb[0]);
        if (outReady) void'(qb.pop_front());
      end
    end
  end

  initial begin
    rst_n     = 1'b0;
    dataIn    = '0;
    inValid   = 1'b0;
    outReady  = 1'b0;
    errClr    = 1'b0;
    thermMode = 1'b0;
    #12;
    check_reset_values();
    @(posedge clk);
    #1;
    rst_n  = 1'b1;
    mon_en = 1'b1;

    // Streaming at full rate
    step(1, 0, 1, 0, 0);
    step(1, 5, 1, 0, 0);
    step(1, 15, 1, 0, 0);
    step(0, 0, 1, 0, 0);
    step(0, 0, 1, 0, 0);

    // Backpressure: 2 and 3 fill OR and SK, 4 waits
    step(1, 2, 0, 0, 0);
    step(1, 3, 0, 0, 0);
    step(1, 4, 0, 0, 0);
    step(1, 4, 0, 0, 0);
    check("stall_inReady", a_inReady, 0);
    step(1, 4, 1, 0, 0);
    step(1, 4, 1, 0, 0);
    step(0, 0, 1, 0, 0);
    step(0, 0, 1, 0, 0);
    step(0, 0, 1, 0, 0);

    // Out of range on the 10-output instance
    step(0, 0, 1, 1, 0);
    step(1, 12, 1, 0, 0);
    step(1, 15, 1, 0, 0);
    step(1, 9, 1, 0, 0);
    step(0, 0, 1, 0, 0);
    step(0, 0, 1, 0, 0);
    check("b_errCount_two", b_errCount, 2);

    // Thermometer beats (plain one-hot in the default build)
    step(1, 3, 1, 0, 1);
    step(1, 7, 1, 0, 1);
    step(1, 7, 1, 0, 0);
    step(1, 12, 1, 0, 1);
    step(0, 0, 1, 0, 0);
    step(0, 0, 1, 0, 0);

    // Saturation, then clear colliding with an out-of-range accept
    for (int i = 0; i < 300; i++) step(1, 15, 1, 0, 0);
    step(0, 0, 1, 0, 0);
    step(0, 0, 1, 0, 0);
    check("b_errCount_sat", b_errCount, 255);
    step(1, 12, 1, 1, 0);
    step(0, 0, 1, 0, 0);
    step(0, 0, 1, 0, 0);
    check("b_errCount_clr", b_errCount, 0);

    // Randomised traffic
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 15), $urandom_range(0, 2) != 0,
           $urandom_range(0, 40) == 0, 1'($urandom));
    end

    // Reset with OR and SK full
    step(1, 6, 0, 0, 0);
    step(1, 12, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    pulse_reset();
    for (int i = 0; i < 4; i++) step(0, 0, 1, 0, 0);
    step(1, 8, 1, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 0, 0);

    @(posedge clk);
    #1;
    commit();
    @(negedge clk);
    #1;
    check("a_drained", qa.size(), 0);
    check("b_drained", qb.size(), 0);
    mon_en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
